// File: rtl/gather_phase_ctrl_if.sv
// Router local-port bundle between a gather controller (master) and its mesh router (slave).
interface gather_phase_ctrl_if;
  logic        pesi;
  logic [63:0] pedi;
  logic        peri;
  logic        pero;
  logic [63:0] pedo;
  logic        peso;

  modport master (output pesi, pedi, pero, input peri, pedo, peso);
  modport slave  (input pesi, pedi, pero, output peri, pedo, peso);
endinterface

// File: rtl/gather_phase_ctrl.sv
// Per-node 16-phase gather scheduler: injects one XY packet to each collector, counts own receipts.
// Optional receive destination check enabled by defining GATHER_RX_CHECK_EN.
module gather_phase_ctrl #(
  parameter int NODE_ID   = 0,
  parameter int PHASE_LEN = 41,
  parameter int NUM_NODES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] payload_in,
  output logic        busy,
  output logic        done,
  output logic [3:0]  phase,
  output logic [4:0]  rx_count,
  output logic        rx_err,
  gather_phase_ctrl_if.master local_port
);

  localparam int              TW         = $clog2(PHASE_LEN);
  localparam logic [TW-1:0]   LAST_T     = TW'(PHASE_LEN - 1);
  localparam logic [3:0]      ME         = 4'(NODE_ID);
  localparam logic [3:0]      LAST_PHASE = 4'(NUM_NODES - 1);
  localparam logic [1:0]      SRC_X      = ME[1:0];
  localparam logic [1:0]      SRC_Y      = ME[3:2];

  typedef enum logic [2:0] {S_IDLE, S_PHASE, S_INJECT, S_HOLD, S_DONE} state_t;

  state_t        state;
  logic [TW-1:0] timer;

  // Header fields are derived from the collector id (the phase number) and this node's position.
  function automatic logic [63:0] build_pkt(input logic [3:0] p, input logic [31:0] pl);
    logic [1:0] dx, dy, hx, hy;
    logic       gx, gy;
    dx = p[1:0];
    dy = p[3:2];
    gx = dx > SRC_X;
    gy = dy > SRC_Y;
    hx = gx ? dx - SRC_X : SRC_X - dx;
    hy = gy ? dy - SRC_Y : SRC_Y - dy;
    return {1'b0, gx, gy, 5'b0, 2'b0, hx, 2'b0, hy, 6'b0, SRC_X, 6'b0, SRC_Y, pl};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      phase           <= 4'd0;
      timer           <= '0;
      rx_count        <= 5'd0;
      local_port.pesi <= 1'b0;
      local_port.pedi <= 64'd0;
      local_port.pero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (local_port.peso && local_port.pero && rx_count != 5'd31)
        rx_count <= rx_count + 5'd1;

      case (state)
        S_IDLE: begin
          if (start) begin
            state           <= S_PHASE;
            phase           <= 4'd0;
            busy            <= 1'b1;
            rx_count        <= 5'd0;
            local_port.pero <= (ME == 4'd0);
          end
        end
        S_PHASE: begin
          timer <= '0;
          if (phase != ME) begin
            state           <= S_INJECT;
            local_port.pesi <= 1'b1;
            local_port.pedi <= build_pkt(phase, payload_in);
          end else begin
            state <= S_HOLD;
          end
        end
        S_INJECT: begin
          // The phase timer keeps running while the router stalls the injection.
          if (timer != LAST_T) timer <= timer + 1'b1;
          if (local_port.peri) begin
            local_port.pesi <= 1'b0;
            state           <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (timer != LAST_T) begin
            timer <= timer + 1'b1;
          end else if (phase == LAST_PHASE) begin
            state           <= S_DONE;
            busy            <= 1'b0;
            done            <= 1'b1;
            local_port.pero <= 1'b0;
          end else begin
            state           <= S_PHASE;
            phase           <= phase + 4'd1;
            local_port.pero <= (phase + 4'd1 == ME);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic unused_pedo;
  assign unused_pedo = ^local_port.pedo;

`ifdef GATHER_RX_CHECK_EN
  logic [7:0] chk_dx, chk_dy;
  logic       chk_bad;

  // Reconstruct the destination the sender aimed at from its source and hop fields.
  always_comb begin
    chk_dx  = local_port.pedo[62] ? local_port.pedo[47:40] + {4'b0, local_port.pedo[55:52]}
                                  : local_port.pedo[47:40] - {4'b0, local_port.pedo[55:52]};
    chk_dy  = local_port.pedo[61] ? local_port.pedo[39:32] + {4'b0, local_port.pedo[51:48]}
                                  : local_port.pedo[39:32] - {4'b0, local_port.pedo[51:48]};
    chk_bad = local_port.pedo[63] || (({chk_dy, 2'b00} + {2'b00, chk_dx}) != 10'(NODE_ID));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rx_err <= 1'b0;
    else if (state == S_IDLE && start)
      rx_err <= 1'b0;
    else if (local_port.peso && local_port.pero && chk_bad)
      rx_err <= 1'b1;
  end
`else
  assign rx_err = 1'b0;
`endif

endmodule
